// File: rtl/apb_dpmem_param_pkg.sv
// Shared types and helpers for the APB dual-port memory slave.
// Pure declarations; no timing or flow-control behaviour of its own.
package apb_dpmem_param_pkg;

   typedef enum logic [1:0] {IDLE, SETUP, ACCESS} apb_fsm_enum;

   typedef enum logic [2:0] {ERR_NONE, ERR_ALIGN, ERR_RANGE, ERR_RO, ERR_PROT} apb_err_e;

   localparam int WAIT_W = 4;

   // Byte address to word index: drop the byte-offset bits of one word.
   function automatic logic [31:0] word_index(input logic [31:0] paddr, input int data_width);
      int sh = 0;
      for (int i = 0; i < 8; i++) begin
         if ((1 << i) == data_width / 8) sh = i;
      end
      return paddr >> sh;
   endfunction

endpackage

// File: rtl/apb_dpmem_param_if.sv
// APB4 completer-side bus bundle; master drives requests, slave returns data/ready/error.
// No storage; the slave sets latency and stalls the master through PREADY.
interface apb_dpmem_param_if
   import apb_dpmem_param_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 8
);
   logic                    PSEL;
   logic                    PENABLE;
   logic                    PWRITE;
   logic [ADDR_WIDTH-1:0]   PADDR;
   logic [DATA_WIDTH-1:0]   PWDATA;
   logic [DATA_WIDTH/8-1:0] PSTRB;
   logic [2:0]              PPROT;
   logic [DATA_WIDTH-1:0]   PRDATA;
   logic                    PREADY;
   logic                    PSLVERR;

   modport master (
      output PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, PPROT,
      input  PRDATA, PREADY, PSLVERR
   );

   modport slave (
      input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, PPROT,
      output PRDATA, PREADY, PSLVERR
   );
endinterface

// File: rtl/apb_dpmem_param_ram.sv
// 1W2R word array: port A strobed write + combinational read, port B registered read.
// Port B has one-cycle latency, accepts a request every cycle and never stalls.
module apb_dpmem_param_ram #(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 64
) (
   input  logic                       i_clk,
   input  logic                       i_rst,
   input  logic                       i_a_we,
   input  logic [DATA_WIDTH/8-1:0]    i_a_strb,
   input  logic [$clog2(DEPTH)-1:0]   i_a_idx,
   input  logic [DATA_WIDTH-1:0]      i_a_wdat,
   output logic [DATA_WIDTH-1:0]      o_a_rdat,
   input  logic                       i_b_en,
   input  logic [$clog2(DEPTH)-1:0]   i_b_idx,
   output logic [DATA_WIDTH-1:0]      o_b_rdat,
   output logic                       o_b_vld
);
   localparam int NB = DATA_WIDTH / 8;

   logic [DATA_WIDTH-1:0] r_mem [DEPTH];
   logic [DATA_WIDTH-1:0] r_b_rdat;
   logic                  r_b_vld;

   always_ff @(posedge i_clk) begin
      if (i_a_we) begin
         for (int i = 0; i < NB; i++) begin
            if (i_a_strb[i]) r_mem[i_a_idx][i*8 +: 8] <= i_a_wdat[i*8 +: 8];
         end
      end
   end

   assign o_a_rdat = r_mem[i_a_idx];

   // Non-blocking update of r_mem means a same-edge collision reads the old word.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_b_vld  <= 1'b0;
         r_b_rdat <= '0;
      end else begin
         r_b_vld <= i_b_en;
         if (i_b_en) r_b_rdat <= r_mem[i_b_idx];
      end
   end

   assign o_b_rdat = r_b_rdat;
   assign o_b_vld  = r_b_vld;
endmodule

// File: rtl/apb_dpmem_param.sv
// APB4 memory slave with RO window, privileged upper half and a native read port B.
// Reads/writes finish after RD_WAIT/WR_WAIT extra ACCESS cycles, errors on the first; port B never stalls APB.
module apb_dpmem_param
   import apb_dpmem_param_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 8,
   parameter int DEPTH      = 64,
   parameter int RD_WAIT    = 1,
   parameter int WR_WAIT    = 3,
   parameter int RO_LO      = 0,
   parameter int RO_HI      = 15
) (
   input  logic                     PCLK,
   input  logic                     PRESET,
   apb_dpmem_param_if.slave         apb,
   input  logic                     b_en,
   input  logic [$clog2(DEPTH)-1:0] b_addr,
   output logic [DATA_WIDTH-1:0]    b_rdata,
   output logic                     b_valid
);
   localparam int          IW         = $clog2(DEPTH);
   localparam logic [31:0] ALIGN_MASK = 32'(DATA_WIDTH / 8 - 1);
   localparam bit          RO_EN      = (RO_HI >= RO_LO);

   apb_fsm_enum           r_state, w_next;
   apb_err_e              r_err, w_err;
   logic [WAIT_W-1:0]     r_wait;
   logic                  r_done;
   logic                  r_write;
   logic [IW-1:0]         r_idx;
   logic [31:0]           w_word;
   logic                  w_ready;
   logic                  w_we;
   logic [DATA_WIDTH-1:0] w_rdat;
   logic                  w_unused;

   assign w_word   = word_index(32'(apb.PADDR), DATA_WIDTH);
   assign w_unused = ^apb.PPROT[2:1];

   // RO test uses unsigned wrap so a zero RO_LO needs no separate lower bound.
   always_comb begin
      w_err = ERR_NONE;
      if ((32'(apb.PADDR) & ALIGN_MASK) != 32'd0)
         w_err = ERR_ALIGN;
      else if (w_word >= 32'(DEPTH))
         w_err = ERR_RANGE;
      else if (apb.PWRITE && RO_EN && ((w_word - 32'(RO_LO)) <= 32'(RO_HI - RO_LO)))
         w_err = ERR_RO;
      else if (apb.PWRITE && !apb.PPROT[0] && (w_word >= 32'(DEPTH / 2)))
         w_err = ERR_PROT;
   end

   assign w_ready = (r_state == ACCESS) && !r_done && apb.PSEL &&
                    ((r_err != ERR_NONE) || (r_wait == '0));
   assign w_we    = w_ready && (r_err == ERR_NONE) && r_write;

   // r_done marks the cycle after completion, where the next setup phase is looked for.
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:   if (apb.PSEL && !apb.PENABLE) w_next = SETUP;
         SETUP:  if (!apb.PSEL) w_next = IDLE;
                 else if (apb.PENABLE) w_next = ACCESS;
         ACCESS: if (r_done) w_next = (apb.PSEL && !apb.PENABLE) ? SETUP : IDLE;
                 else if (!apb.PSEL) w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET) begin
         r_state <= IDLE;
         r_done  <= 1'b0;
         r_wait  <= '0;
         r_err   <= ERR_NONE;
         r_write <= 1'b0;
         r_idx   <= '0;
      end else begin
         r_state <= w_next;
         r_done  <= w_ready;
         if (r_state == SETUP) begin
            r_wait  <= apb.PWRITE ? WAIT_W'(WR_WAIT) : WAIT_W'(RD_WAIT);
            r_err   <= w_err;
            r_write <= apb.PWRITE;
            r_idx   <= w_word[IW-1:0];
         end else if (r_state == ACCESS && r_wait != '0) begin
            r_wait <= r_wait - 1'b1;
         end
      end
   end

   assign apb.PREADY  = w_ready;
   assign apb.PSLVERR = w_ready && (r_err != ERR_NONE);
   assign apb.PRDATA  = (w_ready && (r_err == ERR_NONE) && !r_write) ? w_rdat : '0;

   apb_dpmem_param_ram #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH)
   ) u_ram (
      .i_clk    (PCLK),
      .i_rst    (PRESET),
      .i_a_we   (w_we),
      .i_a_strb (apb.PSTRB),
      .i_a_idx  (r_idx),
      .i_a_wdat (apb.PWDATA),
      .o_a_rdat (w_rdat),
      .i_b_en   (b_en),
      .i_b_idx  (b_addr),
      .o_b_rdat (b_rdata),
      .o_b_vld  (b_valid)
   );
endmodule

// File: tb/tb_apb_dpmem_param.sv
// Directed bench for apb_dpmem_param: APB timing, strobes, error classes, back-to-back, reset, port B.
module tb_apb_dpmem_param;
   import apb_dpmem_param_pkg::*;

   logic        PCLK = 1'b0;
   logic        PRESET;
   logic        b_en;
   logic [5:0]  b_addr;
   logic [31:0] b_rdata;
   logic        b_valid;

   int          checks = 0;
   int          errors = 0;
   logic [31:0] rd;
   logic        er;
   int          n;
   logic [1:0]  st;

   apb_dpmem_param_if #(.DATA_WIDTH(32), .ADDR_WIDTH(8)) bus ();

   apb_dpmem_param #(
      .DATA_WIDTH(32), .ADDR_WIDTH(8), .DEPTH(64),
      .RD_WAIT(1), .WR_WAIT(3), .RO_LO(0), .RO_HI(15)
   ) dut (
      .PCLK    (PCLK),
      .PRESET  (PRESET),
      .apb     (bus),
      .b_en    (b_en),
      .b_addr  (b_addr),
      .b_rdata (b_rdata),
      .b_valid (b_valid)
   );

   always #5 PCLK = ~PCLK;

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout required=finish");
      $fatal(1, "bench timeout");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic apb_start(input logic wr, input logic [7:0] addr, input logic [31:0] wd,
                            input logic [3:0] strb, input logic [2:0] prot);
      @(posedge PCLK); #1;
      bus.PSEL    = 1'b1;
      bus.PENABLE = 1'b0;
      bus.PWRITE  = wr;
      bus.PADDR   = addr;
      bus.PWDATA  = wd;
      bus.PSTRB   = strb;
      bus.PPROT   = prot;
   endtask

   // Returns at the negedge of the completing cycle; n counts ACCESS cycles.
   task automatic apb_finish(output logic [31:0] rdata, output logic err, output int cyc,
                             output logic [1:0] state_en);
      @(posedge PCLK); #1;
      state_en    = dut.r_state;
      bus.PENABLE = 1'b1;
      @(posedge PCLK);
      cyc   = 0;
      rdata = '0;
      err   = 1'b0;
      for (int k = 0; k < 20; k++) begin
         @(negedge PCLK);
         cyc++;
         if (bus.PREADY) begin
            rdata = bus.PRDATA;
            err   = bus.PSLVERR;
            break;
         end
      end
   endtask

   task automatic apb_end();
      @(posedge PCLK); #1;
      bus.PSEL    = 1'b0;
      bus.PENABLE = 1'b0;
   endtask

   task automatic apb_xfer(input logic wr, input logic [7:0] addr, input logic [31:0] wd,
                           input logic [3:0] strb, input logic [2:0] prot,
                           output logic [31:0] rdata, output logic err, output int cyc);
      logic [1:0] s;
      apb_start(wr, addr, wd, strb, prot);
      apb_finish(rdata, err, cyc, s);
      chk("setup_state", 32'(s), 32'(SETUP));
      apb_end();
   endtask

   initial begin
      bus.PSEL = 1'b0; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0; bus.PADDR = '0;
      bus.PWDATA = '0; bus.PSTRB = '0; bus.PPROT = '0;
      b_en = 1'b0; b_addr = '0;
      PRESET = 1'b1;
      dut.u_ram.r_mem[2] = 32'h0BADC0DE;
      repeat (2) @(posedge PCLK);
      @(negedge PCLK);
      chk("rst_pready",  32'(bus.PREADY),  32'd0);
      chk("rst_pslverr", 32'(bus.PSLVERR), 32'd0);
      chk("rst_prdata",  bus.PRDATA,       32'd0);
      chk("rst_bvalid",  32'(b_valid),     32'd0);
      chk("rst_brdata",  b_rdata,          32'd0);
      chk("rst_state",   32'(dut.r_state), 32'(IDLE));
      PRESET = 1'b0;

      // Basic write then read, wait-state timing
      apb_xfer(1'b1, 8'h40, 32'hDEADBEEF, 4'hF, 3'd1, rd, er, n);
      chk("t1_wr_cycles", 32'(n), 32'd4);
      chk("t1_wr_err",    32'(er), 32'd0);
      apb_xfer(1'b0, 8'h40, 32'h0, 4'h0, 3'd1, rd, er, n);
      chk("t1_rd_cycles", 32'(n), 32'd2);
      chk("t1_rd_data",   rd, 32'hDEADBEEF);
      chk("t1_rd_err",    32'(er), 32'd0);

      // Byte strobes
      apb_xfer(1'b1, 8'h80, 32'h11223344, 4'hF, 3'd1, rd, er, n);
      apb_xfer(1'b1, 8'h80, 32'hAAAAAAAA, 4'h5, 3'd1, rd, er, n);
      chk("t2_strb_err", 32'(er), 32'd0);
      apb_xfer(1'b0, 8'h80, 32'h0, 4'h0, 3'd1, rd, er, n);
      chk("t2_strb_data", rd, 32'h11AA33AA);

      // Read-only window and misalignment
      apb_xfer(1'b0, 8'h08, 32'h0, 4'h0, 3'd1, rd, er, n);
      chk("t3_ro_pre", rd, 32'h0BADC0DE);
      apb_xfer(1'b1, 8'h08, 32'hFFFFFFFF, 4'hF, 3'd1, rd, er, n);
      chk("t3_ro_cycles", 32'(n), 32'd1);
      chk("t3_ro_err",    32'(er), 32'd1);
      chk("t3_ro_prdata", rd, 32'd0);
      apb_xfer(1'b0, 8'h08, 32'h0, 4'h0, 3'd1, rd, er, n);
      chk("t3_ro_keep", rd, 32'h0BADC0DE);
      apb_xfer(1'b0, 8'h02, 32'h0, 4'h0, 3'd1, rd, er, n);
      chk("t3_mis_cycles", 32'(n), 32'd1);
      chk("t3_mis_err",    32'(er), 32'd1);
      chk("t3_mis_data",   rd, 32'd0);

      // Privileged upper half
      apb_xfer(1'b1, 8'hC0, 32'h0, 4'hF, 3'd1, rd, er, n);
      apb_xfer(1'b1, 8'hC0, 32'h77, 4'hF, 3'd0, rd, er, n);
      chk("t4_prot_err",    32'(er), 32'd1);
      chk("t4_prot_cycles", 32'(n), 32'd1);
      apb_xfer(1'b0, 8'hC0, 32'h0, 4'h0, 3'd0, rd, er, n);
      chk("t4_prot_keep", rd, 32'd0);
      apb_xfer(1'b1, 8'hC0, 32'h77, 4'hF, 3'd1, rd, er, n);
      chk("t4_priv_err", 32'(er), 32'd0);
      apb_xfer(1'b0, 8'hC0, 32'h0, 4'h0, 3'd0, rd, er, n);
      chk("t4_priv_data", rd, 32'h77);

      // Back-to-back with PSEL held high
      apb_start(1'b1, 8'h44, 32'hCAFEF00D, 4'hF, 3'd1);
      apb_finish(rd, er, n, st);
      chk("t5_b2b_wr_cycles", 32'(n), 32'd4);
      apb_start(1'b0, 8'h44, 32'h0, 4'h0, 3'd1);
      @(negedge PCLK);
      chk("t5_b2b_no_idle", 32'(dut.r_state), 32'(ACCESS));
      apb_finish(rd, er, n, st);
      chk("t5_b2b_setup", 32'(st), 32'(SETUP));
      chk("t5_b2b_rd_data", rd, 32'hCAFEF00D);
      apb_end();

      // Reset in the second write ACCESS cycle
      apb_start(1'b1, 8'h44, 32'h12345678, 4'hF, 3'd1);
      @(posedge PCLK); #1;
      bus.PENABLE = 1'b1;
      @(posedge PCLK);
      @(posedge PCLK);
      @(negedge PCLK);
      chk("t5_rst_in_access", 32'(dut.r_state), 32'(ACCESS));
      PRESET = 1'b1;
      #1;
      chk("t5_rst_pready", 32'(bus.PREADY), 32'd0);
      chk("t5_rst_state",  32'(dut.r_state), 32'(IDLE));
      @(posedge PCLK); #1;
      PRESET = 1'b0;
      bus.PSEL = 1'b0;
      bus.PENABLE = 1'b0;
      apb_xfer(1'b0, 8'h44, 32'h0, 4'h0, 3'd1, rd, er, n);
      chk("t5_rst_nowrite", rd, 32'hCAFEF00D);

      // Port B read-before-write collision
      apb_xfer(1'b1, 8'h40, 32'h0, 4'hF, 3'd1, rd, er, n);
      apb_start(1'b1, 8'h40, 32'h5, 4'hF, 3'd1);
      apb_finish(rd, er, n, st);
      b_en = 1'b1;
      b_addr = 6'd16;
      apb_end();
      @(negedge PCLK);
      chk("t6_col_valid", 32'(b_valid), 32'd1);
      chk("t6_col_old",   b_rdata, 32'd0);
      @(posedge PCLK); #1;
      b_en = 1'b0;
      @(negedge PCLK);
      chk("t6_next_valid", 32'(b_valid), 32'd1);
      chk("t6_next_new",   b_rdata, 32'd5);
      @(negedge PCLK);
      chk("t6_idle_valid", 32'(b_valid), 32'd0);
      chk("t6_idle_hold",  b_rdata, 32'd5);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
